// File: rtl/uart_rx_gen.sv
// -----------------------------------------------------------------------------
// uart_rx_gen
// Oversampling UART receiver with a fractional baud-tick generator, 3-sample
// majority-vote bit recovery, configurable data/parity/stop format and a
// one-entry valid/ready holding register carrying framing/parity status.
// Break frames (everything up to the first stop bit sampled low) produce a
// single BREAK_O pulse instead of a data word.
//
// Ports
//   CLK_I         in   system clock, rising edge
//   RST_NI        in   asynchronous reset, active low
//   RX_I          in   serial line, idle high, asynchronous to CLK_I
//   DATA_O        out  received word, LSB = first bit on the line
//   VALID_O       out  DATA_O / FRAME_ERR_O / PARITY_ERR_O valid
//   READY_I       in   consumer accepts the word when VALID_O && READY_I
//   FRAME_ERR_O   out  held word had a 0 stop bit
//   PARITY_ERR_O  out  held word failed the parity check
//   BREAK_O       out  one-cycle pulse per detected break
//   OVERRUN_O     out  sticky until next handshake: a frame was dropped
//   BUSY_O        out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_gen #(
  parameter int CLK_RATE    = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 RX_I,
  output logic [DATA_BITS-1:0] DATA_O,
  output logic                 VALID_O,
  input  logic                 READY_I,
  output logic                 FRAME_ERR_O,
  output logic                 PARITY_ERR_O,
  output logic                 BREAK_O,
  output logic                 OVERRUN_O,
  output logic                 BUSY_O
);

  localparam int INC = BAUD_RATE * OVERSAMPLE;
  localparam int AW  = $clog2(CLK_RATE + INC) + 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [SW-1:0] SMP_A   = SW'(MID - 1);
  localparam logic [SW-1:0] SMP_B   = SW'(MID);
  localparam logic [SW-1:0] SMP_C   = SW'(MID + 1);
  localparam logic [SW-1:0] SMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DELIVER,
    ST_BRK_WAIT
  } state_t;

  // 2-of-3 vote over the samples around mid-bit
  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity error: data XOR parity bit must be 1 for odd parity, 0 for even
  function automatic logic f_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic want_odd;
    want_odd = (PARITY == 1) ? 1'b1 : 1'b0;
    return ((^d) ^ p) != want_odd;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic [AW-1:0]          r_acc;
  logic [SW-1:0]          r_scnt;
  logic                   r_s0;
  logic                   r_s1;
  state_t                 r_state;
  logic [3:0]             r_bcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_fe;
  logic                   r_pe;
  logic                   r_brk;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_fe_o;
  logic                   r_pe_o;
  logic                   r_break;
  logic                   r_ovr;
  logic                   r_busy;

  logic                   w_rx;
  logic                   w_start_edge;
  logic [AW-1:0]          w_sum;
  logic                   w_tick;
  logic                   w_decide;
  logic                   w_bit;

  assign w_rx = r_sync[SYNC_STAGES-1];

  // Tick generation, edge detect and bit decision strobes
  always_comb begin
    w_sum        = r_acc + AW'(INC);
    w_tick       = (w_sum >= AW'(CLK_RATE));
    w_start_edge = (r_state == ST_IDLE) && r_rx_d && !w_rx;
    w_decide     = w_tick && (r_scnt == SMP_C);
    w_bit        = f_majority(r_s0, r_s1, w_rx);
  end

  // RX synchroniser and previous-value register for falling-edge detection
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_sync <= {SYNC_STAGES{1'b1}};
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX_I};
      r_rx_d <= w_rx;
    end
  end

  // Fractional baud accumulator, sample counter and mid-bit sample capture;
  // both counters restart on the start edge so sampling is phase-aligned
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_acc  <= {AW{1'b0}};
      r_scnt <= {SW{1'b0}};
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else if (w_start_edge) begin
      r_acc  <= {AW{1'b0}};
      r_scnt <= {SW{1'b0}};
    end else begin
      r_acc <= w_tick ? (w_sum - AW'(CLK_RATE)) : w_sum;
      if (w_tick) begin
        r_scnt <= (r_scnt == SMP_END) ? {SW{1'b0}} : (r_scnt + {{(SW-1){1'b0}}, 1'b1});
        if (r_scnt == SMP_A) r_s0 <= w_rx;
        if (r_scnt == SMP_B) r_s1 <= w_rx;
      end
    end
  end

  // Frame FSM plus holding register; later assignments in the case override
  // the handshake defaults so a load in DELIVER wins over the clear
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state <= ST_IDLE;
      r_bcnt  <= 4'd0;
      r_shift <= {DATA_BITS{1'b0}};
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_brk   <= 1'b0;
      r_data  <= {DATA_BITS{1'b0}};
      r_valid <= 1'b0;
      r_fe_o  <= 1'b0;
      r_pe_o  <= 1'b0;
      r_break <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_break <= 1'b0;
      if (r_valid && READY_I) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
        r_data  <= {DATA_BITS{1'b0}};
        r_fe_o  <= 1'b0;
        r_pe_o  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_decide) begin
            if (w_bit) begin
              // glitch shorter than half a bit: silently give up
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
              r_bcnt  <= 4'd0;
              r_brk   <= 1'b1;
              r_fe    <= 1'b0;
              r_pe    <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_decide) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_brk   <= r_brk & ~w_bit;
            if (r_bcnt == LAST_DATA) begin
              r_bcnt  <= 4'd0;
              r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_decide) begin
            r_pe    <= f_parity_err(r_shift, w_bit);
            r_brk   <= r_brk & ~w_bit;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_decide) begin
            if (!w_bit) r_fe <= 1'b1;
            // only the first stop bit takes part in break detection
            if (r_bcnt == 4'd0) r_brk <= r_brk & ~w_bit;
            if (r_bcnt == LAST_STOP) begin
              r_state <= ST_DELIVER;
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
        end
        ST_DELIVER: begin
          if (r_brk) begin
            r_break <= 1'b1;
            r_state <= ST_BRK_WAIT;
          end else begin
            if (!r_valid || READY_I) begin
              r_data  <= r_shift;
              r_fe_o  <= r_fe;
              r_pe_o  <= r_pe;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_BRK_WAIT: begin
          if (w_rx) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_O       = r_data;
  assign VALID_O      = r_valid;
  assign FRAME_ERR_O  = r_fe_o;
  assign PARITY_ERR_O = r_pe_o;
  assign BREAK_O      = r_break;
  assign OVERRUN_O    = r_ovr;
  assign BUSY_O       = r_busy;

endmodule

// File: tb/tb_uart_rx_gen.sv
`timescale 1ns/1ps
// Bench for uart_rx_gen: three instances (8N1, 8E1, 9N2) share clock and
// reset; frames are bit-banged with real-valued delays. Expected words go
// into a scoreboard queue tagged with the instance number; a monitor pops
// and compares on every handshake.
module tb_uart_rx_gen;

  localparam int  CLK_RATE = 10_000_000;
  localparam int  BAUD     = 115200;
  localparam real BIT_NS   = 1.0e9 / 115200.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] ready = 3'b111;
  logic [2:0] valid, fe, pe, brk, ovr, busy;
  logic [2:0][8:0] data;

  int n_tests = 0;
  int n_fail  = 0;
  int brk_cnt [3] = '{0, 0, 0};
  logic [12:0] exp_q [$];
  logic [12:0] mon_exp;
  logic [12:0] mon_got;

  always #50 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DB  = (g == 2) ? 9 : 8;
    localparam int PAR = (g == 1) ? 2 : 0;
    localparam int SB  = (g == 2) ? 2 : 1;
    logic [DB-1:0] w_d;
    uart_rx_gen #(
      .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .OVERSAMPLE(16), .SYNC_STAGES(3)
    ) u_dut (
      .CLK_I(clk), .RST_NI(rst_n), .RX_I(rx[g]), .DATA_O(w_d),
      .VALID_O(valid[g]), .READY_I(ready[g]), .FRAME_ERR_O(fe[g]),
      .PARITY_ERR_O(pe[g]), .BREAK_O(brk[g]), .OVERRUN_O(ovr[g]), .BUSY_O(busy[g])
    );
    assign data[g] = 9'(w_d);
  end

  // Monitor: compare every accepted word against the scoreboard head
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_n && valid[g] && ready[g]) begin
        n_tests++;
        mon_got = {2'(g), fe[g], pe[g], data[g]};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got inst=%0d fe=%b pe=%b data=%h, expected no word",
                   g, fe[g], pe[g], data[g]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp)
            begin
              n_fail++;
              $display("FAIL word: got inst=%0d fe=%b pe=%b data=%h, expected inst=%0d fe=%b pe=%b data=%h",
                       mon_got[12:11], mon_got[10], mon_got[9], mon_got[8:0],
                       mon_exp[12:11], mon_exp[10], mon_exp[9], mon_exp[8:0]);
            end
        end
      end
      if (brk[g]) brk_cnt[g] = brk_cnt[g] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic f, input logic p, input logic [8:0] d);
    exp_q.push_back({2'(g), f, p, d});
  endtask

  // start, nd data bits LSB first, optional parity, ns stop bits, 2 idle bits
  task automatic send_frame(input int g, input logic [8:0] d, input int nd, input bit has_p,
                            input logic pbit, input int ns, input logic stop_v, input real bt);
    rx[g] = 1'b0;
    #(bt);
    for (int i = 0; i < nd; i++) begin
      rx[g] = d[i];
      #(bt);
    end
    if (has_p) begin
      rx[g] = pbit;
      #(bt);
    end
    for (int i = 0; i < ns; i++) begin
      rx[g] = (i == 0) ? stop_v : 1'b1;
      #(bt);
    end
    rx[g] = 1'b1;
    #(2.0 * bt);
  endtask

  task automatic tick_after_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [8:0] t1_vec [3] = '{9'h0A5, 9'h000, 9'h0FF};
  // {data, pbit, expected parity error} for the even-parity instance
  logic [10:0] t2_vec [4] = '{{9'h001, 1'b0, 1'b1}, {9'h001, 1'b1, 1'b0},
                              {9'h003, 1'b0, 1'b0}, {9'h003, 1'b1, 1'b1}};
  int brk_base;

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: got simulation still running, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick_after_edge(5);
    check("reset_flags", 32'({valid, busy, brk, ovr, fe, pe}), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    tick_after_edge(20);
    check("idle_flags", 32'({valid, busy, brk, ovr}), 32'd0);

    // T1: 8N1 words with READY held high
    foreach (t1_vec[i]) begin
      push(0, 1'b0, 1'b0, t1_vec[i]);
      send_frame(0, t1_vec[i], 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
      check("t1_delivered", 32'(exp_q.size()), 32'd0);
    end

    // T2: even parity, good and bad parity bits
    foreach (t2_vec[i]) begin
      push(1, 1'b0, t2_vec[i][0], t2_vec[i][10:2]);
      send_frame(1, t2_vec[i][10:2], 8, 1'b1, t2_vec[i][1], 1, 1'b1, BIT_NS);
      check("t2_delivered", 32'(exp_q.size()), 32'd0);
    end

    // T3: 3-clock glitch is a false start
    @(posedge clk); #1;
    rx[0] = 1'b0;
    tick_after_edge(3);
    rx[0] = 1'b1;
    tick_after_edge(10);
    check("t3_busy_during", 32'(busy[0]), 32'd1);
    tick_after_edge(90);
    check("t3_busy_after", 32'(busy[0]), 32'd0);
    check("t3_no_word", 32'(valid[0]), 32'd0);

    // T4: 20 bit times low, then a normal word
    brk_base = brk_cnt[0];
    rx[0] = 1'b0;
    #(20.0 * BIT_NS);
    check("t4_busy_in_break", 32'(busy[0]), 32'd1);
    rx[0] = 1'b1;
    #(2.0 * BIT_NS);
    check("t4_break_pulses", 32'(brk_cnt[0] - brk_base), 32'd1);
    check("t4_no_word", 32'({valid[0], busy[0]}), 32'd0);
    push(0, 1'b0, 1'b0, 9'h03C);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
    check("t4_delivered", 32'(exp_q.size()), 32'd0);

    // T5: overrun while the holding register is full
    @(posedge clk); #1;
    ready[0] = 1'b0;
    push(0, 1'b0, 1'b0, 9'h011);
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
    check("t5_first_held", 32'({valid[0], ovr[0], data[0]}), 32'({1'b1, 1'b0, 9'h011}));
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
    check("t5_overrun_held", 32'({valid[0], ovr[0], data[0]}), 32'({1'b1, 1'b1, 9'h011}));
    @(posedge clk); #1;
    ready[0] = 1'b1;
    tick_after_edge(2);
    check("t5_after_hs", 32'({valid[0], ovr[0]}), 32'd0);
    check("t5_delivered", 32'(exp_q.size()), 32'd0);

    // T6: zero stop bit, 9N2 at +/-3% line rate, reset mid-frame
    push(0, 1'b1, 1'b0, 9'h07E);
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b0, BIT_NS);
    check("t6_frame_err", 32'(exp_q.size()), 32'd0);
    push(2, 1'b0, 1'b0, 9'h1AB);
    send_frame(2, 9'h1AB, 9, 1'b0, 1'b0, 2, 1'b1, BIT_NS * 0.97);
    push(2, 1'b0, 1'b0, 9'h1AB);
    send_frame(2, 9'h1AB, 9, 1'b0, 1'b0, 2, 1'b1, BIT_NS * 1.03);
    push(2, 1'b0, 1'b0, 9'h055);
    send_frame(2, 9'h055, 9, 1'b0, 1'b0, 2, 1'b1, BIT_NS);
    check("t6_9n2_delivered", 32'(exp_q.size()), 32'd0);

    fork
      send_frame(0, 9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
      begin
        #(4.5 * BIT_NS);
        check("t6_busy_midframe", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_flags", 32'({valid, busy, brk, ovr, fe, pe}), 32'd0);
        check("t6_reset_data", 32'(data), 32'd0);
      end
    join
    tick_after_edge(3);
    rst_n = 1'b1;
    tick_after_edge(20);
    push(0, 1'b0, 1'b0, 9'h05A);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, BIT_NS);
    check("t6_after_reset", 32'(exp_q.size()), 32'd0);

    check("break_totals", 32'({8'(brk_cnt[0]), 8'(brk_cnt[1]), 8'(brk_cnt[2])}), 32'h00010000);
    tick_after_edge(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
